// File: rtl/fetch_decode.sv
// -----------------------------------------------------------------------------
// fetch_decode
//
// Multi-cycle fetch/decode front end for a small RV32I-style core. Each
// instruction walks FETCH -> DECODE -> EXEC and then returns to FETCH.
// An opcode outside {R-type, I-ALU, branch} parks the block in HALT until
// reset. The register file (x0 hardwired to zero) lives here. It is read
// in DECODE and written back from the external execute stage at the end
// of EXEC.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   imem_req/imem_addr  fetch request and byte address (address == pc)
//   imem_ack/imem_rdata fetch handshake and instruction word
//   wb_data             execute-stage result written to x[rd] after EXEC
//   pc_branch           execute-stage branch target
//   muxcontrol          execute-stage branch-taken select
//   aluop, f3, f7       ALU control fields
//   readdata1/2         rs1/rs2 register values
//   immgen              sign-extended immediate
//   alusrc, branch      operand-B select, conditional-branch flag
//   pc                  address of the instruction currently in execute
//   exec_valid          high for the single EXEC cycle
//   halted              illegal opcode trapped
//   instret             retired-instruction counter
// -----------------------------------------------------------------------------
module fetch_decode (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic [31:0] wb_data,
    input  logic [31:0] pc_branch,
    input  logic        muxcontrol,
    output logic [1:0]  aluop,
    output logic [2:0]  f3,
    output logic [6:0]  f7,
    output logic [31:0] readdata1,
    output logic [31:0] readdata2,
    output logic [31:0] immgen,
    output logic        alusrc,
    output logic        branch,
    output logic [31:0] pc,
    output logic        exec_valid,
    output logic        halted,
    output logic [31:0] instret
);

    localparam logic [1:0] FETCH  = 2'd0;
    localparam logic [1:0] DECODE = 2'd1;
    localparam logic [1:0] EXEC   = 2'd2;
    localparam logic [1:0] HALT   = 2'd3;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_B = 7'b1100011;

    logic [1:0]  state_reg, state_next;
    logic [31:0] pc_reg, instr_reg, instret_reg;

    logic [1:0]  aluop_reg, aluop_next;
    logic [2:0]  f3_reg, f3_next;
    logic [6:0]  f7_reg, f7_next;
    logic [31:0] rdata1_reg, rdata1_next;
    logic [31:0] rdata2_reg, rdata2_next;
    logic [31:0] imm_reg, imm_next;
    logic        alusrc_reg, alusrc_next;
    logic        branch_reg, branch_next;
    logic        regwrite_reg, regwrite_next;
    logic        legal_next;

    // Register file flattened into one bus. Slot 0 is tied to zero, so
    // x0 reads 0 and writes to x0 have nowhere to land.
    logic [1023:0] regs_flat;
    logic          wr_en;

    assign wr_en = (state_reg == EXEC) && regwrite_reg;
    assign regs_flat[31:0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_reg
            logic [31:0] x_reg;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    x_reg <= '0;
                end else if (wr_en && (instr_reg[11:7] == 5'(gi))) begin
                    x_reg <= wb_data;
                end
            end
            assign regs_flat[gi*32 +: 32] = x_reg;
        end
    endgenerate

    assign rdata1_next = regs_flat[{instr_reg[19:15], 5'd0} +: 32];
    assign rdata2_next = regs_flat[{instr_reg[24:20], 5'd0} +: 32];

    // Instruction decode from the latched word; registered in DECODE.
    always_comb begin
        aluop_next    = 2'b00;
        alusrc_next   = 1'b0;
        branch_next   = 1'b0;
        regwrite_next = 1'b0;
        imm_next      = '0;
        f3_next       = '0;
        f7_next       = '0;
        legal_next    = 1'b1;
        case (instr_reg[6:0])
            OP_R: begin
                aluop_next    = 2'b10;
                regwrite_next = 1'b1;
                f3_next       = instr_reg[14:12];
                f7_next       = instr_reg[31:25];
            end
            OP_I: begin
                aluop_next    = 2'b10;
                alusrc_next   = 1'b1;
                regwrite_next = 1'b1;
                imm_next      = {{20{instr_reg[31]}}, instr_reg[31:20]};
                f3_next       = instr_reg[14:12];
                // Only the shift-right form uses the upper immediate bits as
                // a function code (srli/srai); elsewhere they are immediate.
                f7_next       = (instr_reg[14:12] == 3'b101) ? instr_reg[31:25] : 7'd0;
            end
            OP_B: begin
                aluop_next  = 2'b01;
                branch_next = 1'b1;
                imm_next    = {{19{instr_reg[31]}}, instr_reg[31], instr_reg[7],
                               instr_reg[30:25], instr_reg[11:8], 1'b0};
                f3_next     = instr_reg[14:12];
                f7_next     = instr_reg[31:25];
            end
            default: legal_next = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FETCH:   if (imem_ack) state_next = DECODE;
            DECODE:  state_next = legal_next ? EXEC : HALT;
            EXEC:    state_next = FETCH;
            default: state_next = HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= FETCH;
            pc_reg       <= '0;
            instr_reg    <= '0;
            instret_reg  <= '0;
            aluop_reg    <= '0;
            f3_reg       <= '0;
            f7_reg       <= '0;
            rdata1_reg   <= '0;
            rdata2_reg   <= '0;
            imm_reg      <= '0;
            alusrc_reg   <= 1'b0;
            branch_reg   <= 1'b0;
            regwrite_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == FETCH && imem_ack) begin
                instr_reg <= imem_rdata;
            end
            if (state_reg == DECODE) begin
                aluop_reg    <= aluop_next;
                f3_reg       <= f3_next;
                f7_reg       <= f7_next;
                rdata1_reg   <= rdata1_next;
                rdata2_reg   <= rdata2_next;
                imm_reg      <= imm_next;
                alusrc_reg   <= alusrc_next;
                branch_reg   <= branch_next;
                regwrite_reg <= regwrite_next;
            end
            if (state_reg == EXEC) begin
                pc_reg      <= (branch_reg && muxcontrol) ? pc_branch : pc_reg + 32'd4;
                instret_reg <= instret_reg + 32'd1;
            end
        end
    end

    // Gating the request with rst_n keeps it low for as long as reset is
    // held and raises it in the very first cycle after release.
    assign imem_req   = (state_reg == FETCH) && rst_n;
    assign imem_addr  = pc_reg;
    assign pc         = pc_reg;
    assign exec_valid = (state_reg == EXEC);
    assign halted     = (state_reg == HALT);
    assign instret    = instret_reg;
    assign aluop      = aluop_reg;
    assign f3         = f3_reg;
    assign f7         = f7_reg;
    assign readdata1  = rdata1_reg;
    assign readdata2  = rdata2_reg;
    assign immgen     = imm_reg;
    assign alusrc     = alusrc_reg;
    assign branch     = branch_reg;

endmodule

// File: tb/tb_fetch_decode.sv
// -----------------------------------------------------------------------------
// tb_fetch_decode
//
// Self-checking bench for fetch_decode. It runs a directed table of
// instructions, then hand-written reset/halt sequences, then a randomized
// instruction stream checked against a small architectural model (register
// array, pc, retired count).
// -----------------------------------------------------------------------------
module tb_fetch_decode;

    logic        clk, rst_n;
    logic        imem_req, imem_ack, muxcontrol;
    logic [31:0] imem_addr, imem_rdata, wb_data, pc_branch;
    logic [1:0]  aluop;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] readdata1, readdata2, immgen, pc, instret;
    logic        alusrc, branch, exec_valid, halted;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [3:0]  delay;
        logic [31:0] wb;
        logic [31:0] pcb;
        logic        mux;
        logic [1:0]  aluop;
        logic        alusrc;
        logic        branch;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] pc_after;
    } vec_t;

    vec_t        tbl [11];
    logic [31:0] m_x [32];
    logic [31:0] m_pc, m_instret;

    fetch_decode dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .wb_data    (wb_data),
        .pc_branch  (pc_branch),
        .muxcontrol (muxcontrol),
        .aluop      (aluop),
        .f3         (f3),
        .f7         (f7),
        .readdata1  (readdata1),
        .readdata2  (readdata2),
        .immgen     (immgen),
        .alusrc     (alusrc),
        .branch     (branch),
        .pc         (pc),
        .exec_valid (exec_valid),
        .halted     (halted),
        .instret    (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_x[i] = '0;
        m_pc      = '0;
        m_instret = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pc"},        pc, 32'd0);
        check({tag, "_addr"},      imem_addr, 32'd0);
        check({tag, "_req"},       32'(imem_req), 32'd0);
        check({tag, "_valid"},     32'(exec_valid), 32'd0);
        check({tag, "_halted"},    32'(halted), 32'd0);
        check({tag, "_instret"},   instret, 32'd0);
        check({tag, "_aluop"},     32'(aluop), 32'd0);
        check({tag, "_f3"},        32'(f3), 32'd0);
        check({tag, "_f7"},        32'(f7), 32'd0);
        check({tag, "_rd1"},       readdata1, 32'd0);
        check({tag, "_rd2"},       readdata2, 32'd0);
        check({tag, "_imm"},       immgen, 32'd0);
        check({tag, "_alusrc"},    32'(alusrc), 32'd0);
        check({tag, "_branch"},    32'(branch), 32'd0);
        $display("reset check %s: pc=%08h req=%0b instret=%0d", tag, pc, imem_req, instret);
    endtask

    // Runs one instruction from a FETCH cycle (entered at a negedge) through
    // EXEC, then updates the architectural model.
    task automatic run_instr(input vec_t v);
        logic [6:0] op;
        logic [4:0] rd;
        op = v.instr[6:0];
        rd = v.instr[11:7];
        for (int i = 0; i <= int'(v.delay); i++) begin
            check("fetch_req", 32'(imem_req), 32'd1);
            check("fetch_addr", imem_addr, m_pc);
            imem_ack   = (i == int'(v.delay));
            imem_rdata = (i == int'(v.delay)) ? v.instr : $urandom;
            @(negedge clk);
        end
        check("decode_req", 32'(imem_req), 32'd0);
        check("decode_valid", 32'(exec_valid), 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = $urandom;
        @(negedge clk);
        imem_ack = 1'b0;
        check("exec_valid", 32'(exec_valid), 32'd1);
        check("exec_aluop", 32'(aluop), 32'(v.aluop));
        check("exec_alusrc", 32'(alusrc), 32'(v.alusrc));
        check("exec_branch", 32'(branch), 32'(v.branch));
        check("exec_imm", immgen, v.imm);
        check("exec_f3", 32'(f3), 32'(v.f3));
        check("exec_f7", 32'(f7), 32'(v.f7));
        check("exec_rd1", readdata1, v.rd1);
        check("exec_rd2", readdata2, v.rd2);
        check("exec_pc", pc, m_pc);
        check("exec_halted", 32'(halted), 32'd0);
        wb_data    = v.wb;
        muxcontrol = v.mux;
        pc_branch  = v.pcb;
        @(negedge clk);
        if ((op == 7'b0110011 || op == 7'b0010011) && rd != 5'd0) m_x[rd] = v.wb;
        m_pc      = v.pc_after;
        m_instret = m_instret + 32'd1;
        check("pc_after", pc, m_pc);
        check("instret_after", instret, m_instret);
        check("after_valid", 32'(exec_valid), 32'd0);
        $display("instr %08h delay %0d -> pc %08h instret %0d", v.instr, v.delay, pc, instret);
    endtask

    task automatic gen_rand(output vec_t v);
        int          kind;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  fn3;
        logic [6:0]  fn7;
        logic [11:0] imm12;
        logic [12:0] off;
        logic [31:0] tmp;
        kind  = $urandom_range(0, 2);
        rd    = 5'($urandom);
        rs1   = 5'($urandom);
        rs2   = 5'($urandom);
        fn3   = 3'($urandom);
        imm12 = 12'($urandom);
        off   = {12'($urandom), 1'b0};
        tmp   = $urandom;
        v       = '0;
        v.delay = 4'($urandom_range(0, 3));
        v.wb    = $urandom;
        v.mux   = 1'($urandom_range(0, 1));
        v.pcb   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : {tmp[31:2], 2'b00};
        v.f3    = fn3;
        v.rd1   = m_x[rs1];
        case (kind)
            0: begin
                fn7        = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                v.instr    = {fn7, rs2, rs1, fn3, rd, 7'b0110011};
                v.aluop    = 2'b10;
                v.f7       = fn7;
                v.rd2      = m_x[rs2];
                v.pc_after = m_pc + 32'd4;
            end
            1: begin
                v.instr    = {imm12, rs1, fn3, rd, 7'b0010011};
                v.aluop    = 2'b10;
                v.alusrc   = 1'b1;
                v.imm      = 32'($signed(imm12));
                v.f7       = (fn3 == 3'b101) ? imm12[11:5] : 7'd0;
                v.rd2      = m_x[imm12[4:0]];
                v.pc_after = m_pc + 32'd4;
            end
            default: begin
                v.instr    = {off[12], off[10:5], rs2, rs1, fn3, off[4:1], off[11], 7'b1100011};
                v.aluop    = 2'b01;
                v.branch   = 1'b1;
                v.imm      = 32'($signed(off));
                v.f7       = v.instr[31:25];
                v.rd2      = m_x[rs2];
                v.pc_after = v.mux ? v.pcb : m_pc + 32'd4;
            end
        endcase
    endtask

    initial begin
        vec_t v;
        // instr, delay, wb, pcb, mux, aluop, alusrc, branch, imm, f3, f7, rd1, rd2, pc_after
        tbl[0]  = '{32'h00500093, 4'd0, 32'd5,        32'd0, 1'b0, 2'd2, 1'b1, 1'b0, 32'd5,        3'd0, 7'h00, 32'd0,        32'd0,        32'h04};
        tbl[1]  = '{32'h00108133, 4'd0, 32'd10,       32'd0, 1'b0, 2'd2, 1'b0, 1'b0, 32'd0,        3'd0, 7'h00, 32'd5,        32'd5,        32'h08};
        tbl[2]  = '{32'h00210033, 4'd1, 32'h1234,     32'd0, 1'b0, 2'd2, 1'b0, 1'b0, 32'd0,        3'd0, 7'h00, 32'd10,       32'd10,       32'h0C};
        tbl[3]  = '{32'h00700013, 4'd0, 32'd7,        32'd0, 1'b0, 2'd2, 1'b1, 1'b0, 32'd7,        3'd0, 7'h00, 32'd0,        32'd0,        32'h10};
        tbl[4]  = '{32'hFE000CE3, 4'd0, 32'hDEAD,     32'h8, 1'b1, 2'd1, 1'b0, 1'b1, 32'hFFFFFFF8, 3'd0, 7'h7F, 32'd0,        32'd0,        32'h08};
        tbl[5]  = '{32'h00208033, 4'd2, 32'd0,        32'd0, 1'b0, 2'd2, 1'b0, 1'b0, 32'd0,        3'd0, 7'h00, 32'd5,        32'd10,       32'h0C};
        tbl[6]  = '{32'hFFF00193, 4'd0, 32'hFFFFFFFF, 32'd0, 1'b0, 2'd2, 1'b1, 1'b0, 32'hFFFFFFFF, 3'd0, 7'h00, 32'd0,        32'd0,        32'h10};
        tbl[7]  = '{32'hFE118CE3, 4'd0, 32'hBEEF,     32'h8, 1'b0, 2'd1, 1'b0, 1'b1, 32'hFFFFFFF8, 3'd0, 7'h7F, 32'hFFFFFFFF, 32'd5,        32'h14};
        tbl[8]  = '{32'h4031D213, 4'd4, 32'h1FFFFFFF, 32'd0, 1'b0, 2'd2, 1'b1, 1'b0, 32'h403,      3'd5, 7'h20, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h18};
        tbl[9]  = '{32'h80000293, 4'd0, 32'h55,       32'd0, 1'b0, 2'd2, 1'b1, 1'b0, 32'hFFFFF800, 3'd0, 7'h00, 32'd0,        32'd0,        32'h1C};
        tbl[10] = '{32'h005C8033, 4'd0, 32'd0,        32'd0, 1'b0, 2'd2, 1'b0, 1'b0, 32'd0,        3'd0, 7'h00, 32'd0,        32'h55,       32'h20};

        rst_n      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        wb_data    = '0;
        pc_branch  = '0;
        muxcontrol = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;
        @(negedge clk);
        check("release_req", 32'(imem_req), 32'd1);
        check("release_addr", imem_addr, 32'd0);

        for (int i = 0; i < 11; i++) run_instr(tbl[i]);

        // Illegal opcode: trap and stay put, ignoring acks.
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000007F;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            check("halt_halted", 32'(halted), 32'd1);
            check("halt_req", 32'(imem_req), 32'd0);
            check("halt_valid", 32'(exec_valid), 32'd0);
            check("halt_pc", pc, m_pc);
            check("halt_instret", instret, m_instret);
            imem_ack   = i[0];
            imem_rdata = 32'h00500093;
            @(negedge clk);
            $display("halt cycle %0d: halted=%0b req=%0b pc=%08h", i, halted, imem_req, pc);
        end
        imem_ack = 1'b0;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("halt_reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("halt_release_req", 32'(imem_req), 32'd1);

        // Reset on the same edge as an ack: the ack is dropped.
        imem_ack   = 1'b1;
        imem_rdata = 32'h00500093;
        rst_n      = 1'b0;
        @(negedge clk);
        imem_ack = 1'b0;
        check("ackrst_req_low", 32'(imem_req), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ackrst_req", 32'(imem_req), 32'd1);
        check("ackrst_addr", imem_addr, 32'd0);
        check("ackrst_valid", 32'(exec_valid), 32'd0);
        @(negedge clk);
        check("ackrst_still_fetch", 32'(imem_req), 32'd1);
        $display("ack-during-reset: req=%0b addr=%08h", imem_req, imem_addr);
        model_reset();

        // addi x7,x0,3 then reset during EXEC of addi x6,x0,9.
        run_instr('{32'h00300393, 4'd0, 32'd3, 32'd0, 1'b0, 2'd2, 1'b1, 1'b0, 32'd3, 3'd0, 7'h00, 32'd0, 32'd0, 32'h04});
        imem_ack   = 1'b1;
        imem_rdata = 32'h00900313;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        check("rstexec_valid", 32'(exec_valid), 32'd1);
        check("rstexec_imm", immgen, 32'd9);
        check("rstexec_pc", pc, 32'd4);
        wb_data = 32'd9;
        rst_n   = 1'b0;
        @(negedge clk);
        check("rstexec_pc_after", pc, 32'd0);
        check("rstexec_instret", instret, 32'd0);
        check("rstexec_valid_after", 32'(exec_valid), 32'd0);
        check("rstexec_req", 32'(imem_req), 32'd0);
        check("rstexec_imm_cleared", immgen, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rstexec_release_req", 32'(imem_req), 32'd1);
        check("rstexec_release_addr", imem_addr, 32'd0);
        $display("reset-in-exec: pc=%08h instret=%0d", pc, instret);
        model_reset();
        // add x0,x6,x7: both registers must read 0 after reset.
        run_instr('{32'h00730033, 4'd0, 32'd0, 32'd0, 1'b0, 2'd2, 1'b0, 1'b0, 32'd0, 3'd0, 7'h00, 32'd0, 32'd0, 32'h04});

        for (int n = 0; n < 150; n++) begin
            gen_rand(v);
            run_instr(v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_decode.md
FETCH_DECODE -- requirements
Module: fetch_decode

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset.
REQ-002 The ports SHALL be, clock and reset first:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  32  fetch byte address, equals pc
- imem_ack  in  1  fetch data valid this cycle
- imem_rdata  in  32  fetched instruction
- wb_data  in  32  execute-stage result (alu_output)
- pc_branch  in  32  execute-stage branch target
- muxcontrol  in  1  execute-stage branch-taken select
- aluop  out  2  ALU op class
- f3  out  3  instr[14:12]
- f7  out  7  instr[31:25]
- readdata1  out  32  rs1 value
- readdata2  out  32  rs2 value
- immgen  out  32  sign-extended immediate
- alusrc  out  1  1 selects immgen as ALU operand B
- branch  out  1  instruction is a conditional branch
- pc  out  32  address of the instruction in execute
- exec_valid  out  1  decode outputs valid; execute results sampled this cycle
- halted  out  1  illegal opcode trapped
- instret  out  32  retired-instruction count

Function
REQ-003 The FSM SHALL have states FETCH, DECODE, EXEC and HALT; the reset state is FETCH.
REQ-004 In FETCH: imem_req=1 and imem_addr=pc; both SHALL hold stable until imem_ack=1.
REQ-005 On FETCH with imem_ack=1, the block SHALL latch imem_rdata and go to DECODE next cycle; imem_req SHALL be 0 in that next cycle.
REQ-006 imem_ack SHALL be ignored outside FETCH.
REQ-007 DECODE SHALL register all decode outputs, including register-file reads of rs1=instr[19:15] and rs2=instr[24:20], then go to EXEC; DECODE lasts one cycle.
REQ-008 Opcode 0110011 (R-type) SHALL decode as aluop=10, alusrc=0, branch=0, regwrite=1, immgen=0.
REQ-009 Opcode 0010011 (I-ALU) SHALL decode as aluop=10, alusrc=1, branch=0, regwrite=1, immgen=sext(instr[31:20]).
- f7 SHALL be forced to 0000000 unless f3 is 101.
REQ-010 Opcode 1100011 (branch) SHALL decode as aluop=01, alusrc=0, branch=1, regwrite=0.
- immgen = sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}), a byte offset.
REQ-011 Any other opcode SHALL go from DECODE to HALT with halted=1.
- HALT is left only by reset.
- In HALT: exec_valid=0 and imem_req=0.
REQ-012 EXEC SHALL last exactly one cycle with exec_valid=1; all decode outputs and pc SHALL stay constant during EXEC.
REQ-013 At the end of EXEC, if regwrite=1 and rd=instr[11:7] is nonzero, wb_data SHALL be written to x[rd].
REQ-014 At the end of EXEC, pc SHALL become pc_branch if branch=1 and muxcontrol=1, else pc+4 modulo 2^32.
- Wrap: 0xFFFFFFFC+4 = 0x00000000.
REQ-015 At the end of EXEC, instret SHALL increment by 1 (wrapping at 2^32) and the FSM SHALL return to FETCH.
REQ-016 Register file: 32x32, with x0 reading 0 always; writes to x0 SHALL be discarded.
REQ-017 Read-during-write cannot occur, since writes happen only in EXEC and reads only in DECODE; no bypass SHALL be implemented.
REQ-018 Throughput SHALL be one instruction per (fetch wait + 3) cycles; with imem_ack in the first FETCH cycle, that is 3 cycles per instruction.

Reset
REQ-019 While rst_n=0 at a clock edge, the next-cycle outputs SHALL be:
- pc=0, imem_addr=0, state=FETCH
- imem_req=0, exec_valid=0, halted=0, instret=0
- all decode outputs 0
- all registers x1..x31 = 0
REQ-020 On the first cycle after rst_n returns high, imem_req SHALL be 1 with imem_addr=0.
REQ-021 Reset asserted in any state, including mid-fetch or EXEC, SHALL take priority:
- no register write
- no pc update
- no instret increment
- a pending imem_ack SHALL be dropped

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset, then ack at once with addi x1,x0,5 (0x00500093) and wb_data=5: aluop=10, alusrc=1, immgen=5 during EXEC; afterwards x1=5, pc=4, instret=1.
- add x2,x1,x1 with x1=5: readdata1=readdata2=5, aluop=10, alusrc=0 in EXEC; with wb_data=10, x2=10 afterwards.
- beq with offset -8 at pc=0x10, muxcontrol=1, pc_branch=0x08: immgen=0xFFFFFFF8, branch=1, no register write; next imem_addr=0x08. With muxcontrol=0 instead: next imem_addr=0x14.
- imem_ack delayed 4 cycles: imem_req and imem_addr are stable across all 4 cycles; DECODE follows the ack cycle.
- addi x0,x0,7 with wb_data=7: x0 still reads 0. Illegal opcode 0x0000007F: halted=1, imem_req=0 permanently until reset.
- rst_n low during an EXEC cycle with regwrite: no write occurs, pc=0, instret=0.
